// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ALU among NUM_REQ requesters, one op in flight.
// Optional macro ALU_ARB_PRIO_EN: requester 0 always wins in IDLE and leaves rr_ptr untouched.
module alu_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned ALU_LATENCY = 2,
    parameter int unsigned ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          alu_start,
    output logic [DATA_WIDTH-1:0]         alu_operand,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    output logic                          rsp_valid,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic                          rsp_ready,
    output logic                          busy
);

    localparam int unsigned CntWidth = $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [CntWidth-1:0]   r_cnt;
    logic [DATA_WIDTH-1:0] r_operand;
    logic [ID_WIDTH-1:0]   r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_gnt_idx;
    logic [ID_WIDTH-1:0]   w_idx;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_WIDTH-1:0]   w_ptr_next;

    // First valid requester at or above rr_ptr, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        w_grant   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = ID_WIDTH'((32'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
`ifdef ALU_ARB_PRIO_EN
        if (req_valid[0]) begin
            w_found   = 1'b1;
            w_gnt_idx = '0;
        end
`endif
        if (r_state == StIdle && w_found) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_ptr_next = ID_WIDTH'((32'(r_rsp_id) + 1) % NUM_REQ);
`ifdef ALU_ARB_PRIO_EN
        if (r_rsp_id == '0) begin
            w_ptr_next = r_rr_ptr;
        end
`endif
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_found) w_state_next = StIssue;
            StIssue: w_state_next = StWait;
            StWait:  if (r_cnt == CntWidth'(1)) w_state_next = StResp;
            StResp:  if (rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_n) begin
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            r_operand  <= '0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_operand <= req_data[32'(w_gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
                        r_rsp_id  <= w_gnt_idx;
                    end
                end
                StIssue: r_cnt <= CntWidth'(ALU_LATENCY);
                StWait: begin
                    r_cnt <= r_cnt - CntWidth'(1);
                    if (r_cnt == CntWidth'(1)) begin
                        r_rsp_data <= alu_result;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rr_ptr <= w_ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = w_grant;
    assign alu_start   = (r_state == StIssue);
    assign alu_operand = r_operand;
    assign rsp_valid   = (r_state == StResp);
    assign rsp_id      = r_rsp_id;
    assign rsp_data    = r_rsp_data;
    assign busy        = (r_state != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter against a transaction-timeline reference model and an ALU model.
// Honours ALU_ARB_PRIO_EN in the reference model.
module tb_alu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 12;
    localparam int LAT     = 2;
    localparam int IDW     = 2;
    localparam int NCYC    = 2000;

    logic                  clk_in = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  alu_start;
    logic [DW-1:0]         alu_operand;
    logic [DW-1:0]         alu_result;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [DW-1:0]         rsp_data;
    logic                  rsp_ready;
    logic                  busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk_in = ~clk_in;

    alu_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .ALU_LATENCY(LAT),
        .ID_WIDTH   (IDW)
    ) u_dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .alu_start  (alu_start),
        .alu_operand(alu_operand),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] x);
        return (x * 12'd5) ^ 12'h3C6;
    endfunction

    // ALU model: result of the op started at S is valid during cycle S+LAT only.
    logic [DW-1:0] alu_pipe [LAT];
    always @(posedge clk_in) begin
        alu_pipe[0] <= alu_start ? alu_operand : DW'($urandom);
        for (int k = 1; k < LAT; k++) alu_pipe[k] <= alu_pipe[k-1];
    end
    assign alu_result = alu_f(alu_pipe[LAT-1]);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
`ifdef ALU_ARB_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic drive(input int cyc);
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = DW'($urandom);
        rst_n = 1'b0;
        if (cyc < 12) begin
            req_valid = 4'b0010;
            req_data[DW +: DW] = 12'h0A5;
            rsp_ready = 1'b1;
        end else if (cyc < 60) begin
            req_valid = 4'b1111;
            rsp_ready = 1'b1;
        end else if (cyc < 120) begin
            req_valid = NUM_REQ'($urandom);
            rsp_ready = ($urandom_range(0, 4) == 0);
        end else if (cyc < 160) begin
            req_valid = 4'b1000;
            rsp_ready = 1'b1;
        end else if (cyc < 200) begin
            req_valid = 4'b1001;
            rsp_ready = 1'b1;
        end else begin
            req_valid = NUM_REQ'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            rst_n     = ($urandom_range(0, 59) == 0);
        end
    endtask

    // Model: m_age = cycles since accept (0 = idle); start at 1, response from LAT+2.
    int               m_age = 0;
    int               m_ptr = 0;
    int               m_id  = 0;
    logic [DW-1:0]    m_op  = '0;
    int               g;
    logic [NUM_REQ-1:0] exp_ready;

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_eq("rst_req_ready", 32'(req_ready), 32'(0));
        check_eq("rst_alu_start", 32'(alu_start), 32'(0));
        check_eq("rst_alu_operand", 32'(alu_operand), 32'(0));
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check_eq("rst_rsp_id", 32'(rsp_id), 32'(0));
        check_eq("rst_rsp_data", 32'(rsp_data), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        @(posedge clk_in);
        #1;
        drive(0);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            g = (m_age == 0) ? pick(req_valid, m_ptr) : -1;
            exp_ready = (g >= 0) ? NUM_REQ'(1 << g) : '0;
            @(negedge clk_in);
            check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
            check_eq("busy", 32'(busy), 32'(m_age != 0));
            check_eq("alu_start", 32'(alu_start), 32'(m_age == 1));
            check_eq("rsp_valid", 32'(rsp_valid), 32'(m_age >= LAT + 2));
            if (m_age == 1) check_eq("alu_operand", 32'(alu_operand), 32'(m_op));
            if (m_age >= LAT + 2) begin
                check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
                check_eq("rsp_data", 32'(rsp_data), 32'(alu_f(m_op)));
            end

            if (rst_n) begin
                m_age = 0;
                m_ptr = 0;
            end else if (m_age == 0) begin
                if (g >= 0) begin
                    m_age = 1;
                    m_id  = g;
                    m_op  = req_data[g*DW +: DW];
                end
            end else if (m_age >= LAT + 2) begin
                if (rsp_ready) begin
                    m_age = 0;
`ifdef ALU_ARB_PRIO_EN
                    if (m_id != 0) m_ptr = (m_id + 1) % NUM_REQ;
`else
                    m_ptr = (m_id + 1) % NUM_REQ;
`endif
                end
            end else begin
                m_age++;
            end

            @(posedge clk_in);
            #1;
            drive(cyc + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
